branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Back end of the branch predictor loop. Records every branch prediction issued at fetch in an in-order queue.
- When EX resolves a branch, it compares the actual outcome with the recorded prediction.
- Produces the predictor update bundle (fact_pc, fact_tpc, fact_taken, predict_dir_fail, predict_add_fail) and a front-end redirect.
- Sits between the fetch/predict stage (push side) and EX branch resolution (pop side).

Parameters:
- DEPTH_LOG, 3, log2 of queue depth (8 entries).
- CNT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- push_valid  in  1  fetch pushes one branch record.
- push_ready  out  1  queue can accept a push this cycle.
- push_pc  in  32  branch instruction PC.
- push_pred_pc  in  32  predicted target from the predictor.
- push_pred_taken  in  2  per-slot taken bits from the predictor.
- push_hit  in  1  predictor tag hit.
- res_valid  in  1  EX resolves the oldest outstanding branch.
- res_taken  in  1  actual direction.
- res_tpc  in  32  actual target.
- flush  in  1  external pipeline flush (exception/ertn).
- fact_pc  out  32  update: branch PC.
- fact_tpc  out  32  update: actual target.
- fact_taken  out  1  update: actual direction.
- predict_dir_fail  out  1  update: direction mispredicted.
- predict_add_fail  out  1  update: taken both ways, target differs.
- redirect_valid  out  1  front-end redirect pulse.
- redirect_pc  out  32  correct next PC.
- empty  out  1  no outstanding entries.
- res_err  out  1  sticky: resolve arrived while queue empty.

Behaviour:
- Storage: 2^DEPTH_LOG entries {pc, pred_tpc, pred_dir}. Head and tail pointers are DEPTH_LOG bits and wrap modulo depth. Occupancy counter is DEPTH_LOG+1 bits.
- pred_dir at push = push_hit & push_pred_taken[push_pc[2]]. Bit index is pc[2], matching the predictor's per-slot encoding.
- push_ready = (count != depth). Combinational from registered count only; no same-cycle pop bypass.
- A push is accepted when push_valid & push_ready. The entry is written at tail; tail and count increment on the next edge.
- A resolve with res_valid & !empty pops the head entry and computes:
  - dir_fail = pred_dir != res_taken.
  - add_fail = pred_dir & res_taken & (pred_tpc != res_tpc).
- All update outputs are registered, one cycle after res_valid:
  - fact_pc = entry.pc; fact_tpc = res_tpc; fact_taken = res_taken.
  - predict_dir_fail and predict_add_fail are single-cycle pulses, 0 otherwise.
  - The fact_* registers hold their last value between resolves.
- Redirect: redirect_valid pulses in the same cycle as the fail pulses when dir_fail | add_fail.
  - redirect_pc = res_taken ? res_tpc : entry.pc + 4.
- Mispredict flush: on the resolving edge with a mispredict, head and tail reset to 0 and count to 0; all younger entries are discarded.
  - A push in that same cycle is dropped, because it is on the wrong path.
- External flush: on the next edge, pointers and count go to 0 and no update is generated.
  - flush has priority over both push and resolve in the same cycle; the resolve is lost and no pulse is issued.
- Push and correct resolve in the same cycle: both take effect and count is unchanged. When full, push_ready is already 0.
- Resolve while empty: ignored (no pulses) and res_err is set to 1. res_err clears only on reset.
- Reset (rstn=0 on an edge), including mid-operation:
  - Pointers, count, fail pulses, redirect_valid and res_err go to 0.
  - fact_pc and fact_tpc go to 0x0, fact_taken to 0, redirect_pc to 0x0.
  - Entry storage is not cleared.
- empty = (count == 0).

Optional Feature:
- Macro: BRQ_STAT_EN.
- When defined, adds outputs stat_resolved and stat_mispred, each CNT_WIDTH bits.
  - stat_resolved increments on each accepted resolve.
  - stat_mispred increments on each dir_fail | add_fail.
  - Both saturate at all-ones and reset to 0. Neither clears on flush.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Push pc=0x1C000004, hit=1, pred_taken=2'b10, pred_tpc=0x1C000100; resolve taken, tpc=0x1C000100 -> next cycle: no fail pulses, no redirect, fact_pc=0x1C000004, empty=1.
- Push pc=0x1C000010, hit=0; resolve taken, tpc=0x1C000200 -> dir_fail=1, add_fail=0, redirect_pc=0x1C000200.
- Push pc=0x1C000020, hit=1, pred_taken=2'b01, tpc=0x1C000300; resolve taken, tpc=0x1C000400 -> add_fail=1, dir_fail=0, redirect_pc=0x1C000400. Same test with resolve not-taken -> dir_fail=1, redirect_pc=0x1C000024.
- Push 8 entries -> push_ready=0 and the 9th push is ignored. Resolve all 8 correctly, pushing concurrently -> in-order fact_pc sequence, pointers wrap, count stays consistent.
- 3 entries queued; first resolve mispredicts while push_valid=1 -> empty=1 after the edge and the pushed entry is dropped. Separately, flush together with res_valid -> no pulses, empty=1.
- Resolve on an empty queue -> res_err=1 and stays 1. Then drive rstn=0 for one edge -> res_err=0, all outputs at reset values.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order record of fetch-time branch predictions, checked at EX resolve.
// Optional BRQ_STAT_EN adds saturating resolve/mispredict counters.  Rev 1.0
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH_LOG = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [31:0]          push_pc,
  input  logic [31:0]          push_pred_pc,
  input  logic [1:0]           push_pred_taken,
  input  logic                 push_hit,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [31:0]          res_tpc,
  input  logic                 flush,
  output logic [31:0]          fact_pc,
  output logic [31:0]          fact_tpc,
  output logic                 fact_taken,
  output logic                 predict_dir_fail,
  output logic                 predict_add_fail,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 empty,
`ifdef BRQ_STAT_EN
  output logic [CNT_WIDTH-1:0] stat_resolved,
  output logic [CNT_WIDTH-1:0] stat_mispred,
`endif
  output logic                 res_err
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] c_depth = (DEPTH_LOG+1)'(DEPTH);

  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] tpc_mem [DEPTH];
  logic        dir_mem [DEPTH];

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 res_err_q, res_err_d;

  logic [31:0] fact_pc_q, fact_pc_d;
  logic [31:0] fact_tpc_q, fact_tpc_d;
  logic        fact_taken_q, fact_taken_d;
  logic        dir_fail_q, dir_fail_d;
  logic        add_fail_q, add_fail_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        w_empty;
  logic        w_push_acc;
  logic        w_res_acc;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_tpc;
  logic        w_head_dir;
  logic        w_dir_fail;
  logic        w_add_fail;
  logic        w_mispred;

  assign w_empty    = (count_q == '0);
  assign push_ready = (count_q != c_depth);
  assign w_push_acc = push_valid & push_ready;
  assign w_res_acc  = res_valid & ~w_empty & ~flush;

  assign w_head_pc  = pc_mem[head_q];
  assign w_head_tpc = tpc_mem[head_q];
  assign w_head_dir = dir_mem[head_q];

  assign w_dir_fail = (w_head_dir != res_taken);
  assign w_add_fail = w_head_dir & res_taken & (w_head_tpc != res_tpc);
  assign w_mispred  = w_res_acc & (w_dir_fail | w_add_fail);

  // Storage is written on every accepted push; a push dropped by a mispredict
  // lands in a slot the pointer reset immediately abandons.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      pc_mem[tail_q]  <= push_pc;
      tpc_mem[tail_q] <= push_pred_pc;
      dir_mem[tail_q] <= push_hit & push_pred_taken[push_pc[2]];
    end
  end

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    res_err_d    = res_err_q;
    fact_pc_d    = fact_pc_q;
    fact_tpc_d   = fact_tpc_q;
    fact_taken_d = fact_taken_q;
    dir_fail_d   = 1'b0;
    add_fail_d   = 1'b0;
    redir_d      = 1'b0;
    redir_pc_d   = redir_pc_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (res_valid & w_empty) begin
        res_err_d = 1'b1;
      end
      if (w_res_acc) begin
        fact_pc_d    = w_head_pc;
        fact_tpc_d   = res_tpc;
        fact_taken_d = res_taken;
        dir_fail_d   = w_dir_fail;
        add_fail_d   = w_add_fail;
      end
      if (w_mispred) begin
        // Everything younger is on the wrong path, including a same-cycle push.
        redir_d    = 1'b1;
        redir_pc_d = res_taken ? res_tpc : (w_head_pc + 32'd4);
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
      end else begin
        if (w_push_acc) begin
          tail_d = tail_q + DEPTH_LOG'(1);
        end
        if (w_res_acc) begin
          head_d = head_q + DEPTH_LOG'(1);
        end
        count_d = count_q + {{DEPTH_LOG{1'b0}}, w_push_acc}
                          - {{DEPTH_LOG{1'b0}}, w_res_acc};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      res_err_q    <= 1'b0;
      fact_pc_q    <= 32'h0;
      fact_tpc_q   <= 32'h0;
      fact_taken_q <= 1'b0;
      dir_fail_q   <= 1'b0;
      add_fail_q   <= 1'b0;
      redir_q      <= 1'b0;
      redir_pc_q   <= 32'h0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      res_err_q    <= res_err_d;
      fact_pc_q    <= fact_pc_d;
      fact_tpc_q   <= fact_tpc_d;
      fact_taken_q <= fact_taken_d;
      dir_fail_q   <= dir_fail_d;
      add_fail_q   <= add_fail_d;
      redir_q      <= redir_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

`ifdef BRQ_STAT_EN
  logic [CNT_WIDTH-1:0] stat_res_q, stat_res_d;
  logic [CNT_WIDTH-1:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (w_res_acc && (stat_res_q != '1)) begin
      stat_res_d = stat_res_q + CNT_WIDTH'(1);
    end
    if (w_mispred && (stat_mis_q != '1)) begin
      stat_mis_d = stat_mis_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`endif

  assign fact_pc          = fact_pc_q;
  assign fact_tpc         = fact_tpc_q;
  assign fact_taken       = fact_taken_q;
  assign predict_dir_fail = dir_fail_q;
  assign predict_add_fail = add_fail_q;
  assign redirect_valid   = redir_q;
  assign redirect_pc      = redir_pc_q;
  assign empty            = w_empty;
  assign res_err          = res_err_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for branch_resolve_queue.  Rev 1.0
`default_nettype none

module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_pred_pc;
  logic [1:0]  push_pred_taken;
  logic        push_hit;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_tpc;
  logic        flush;
  logic [31:0] fact_pc;
  logic [31:0] fact_tpc;
  logic        fact_taken;
  logic        predict_dir_fail;
  logic        predict_add_fail;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        empty;
  logic        res_err;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH_LOG(3), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_pred_pc     (push_pred_pc),
    .push_pred_taken  (push_pred_taken),
    .push_hit         (push_hit),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_tpc          (res_tpc),
    .flush            (flush),
    .fact_pc          (fact_pc),
    .fact_tpc         (fact_tpc),
    .fact_taken       (fact_taken),
    .predict_dir_fail (predict_dir_fail),
    .predict_add_fail (predict_add_fail),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .empty            (empty),
    .res_err          (res_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tpc;
    logic        dir;
  } entry_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tpc;
    logic        taken;
    logic        dfail;
    logic        afail;
    logic [31:0] rpc;
  } result_t;

  entry_t  model_q[$];
  result_t sb_q[$];
  logic    model_err;
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then compare after the edge.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] ppc,
                      input logic [1:0] pt, input logic hit,
                      input logic rv, input logic tk, input logic [31:0] tpc,
                      input logic fl);
    entry_t  e;
    result_t r;
    logic    ready;
    logic    got;
    push_valid = pv; push_pc = pc; push_pred_pc = ppc; push_pred_taken = pt; push_hit = hit;
    res_valid = rv; res_taken = tk; res_tpc = tpc; flush = fl;
    ready = (model_q.size() != 8);
    check("push_ready", {31'b0, push_ready}, {31'b0, ready});
    got = 1'b0;
    if (fl) begin
      model_q.delete();
    end else begin
      logic mis;
      mis = 1'b0;
      if (rv && model_q.size() == 0) model_err = 1'b1;
      if (rv && model_q.size() != 0) begin
        e = model_q.pop_front();
        r.pc = e.pc; r.tpc = tpc; r.taken = tk;
        r.dfail = (e.dir != tk);
        r.afail = e.dir & tk & (e.tpc != tpc);
        r.rpc = tk ? tpc : e.pc + 32'd4;
        mis = r.dfail | r.afail;
        sb_q.push_back(r);
        got = 1'b1;
        if (mis) model_q.delete();
      end
      if (pv && ready && !mis) begin
        e.pc = pc; e.tpc = ppc; e.dir = hit & pt[pc[2]];
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (got) begin
      r = sb_q.pop_front();
      check("fact_pc", fact_pc, r.pc);
      check("fact_tpc", fact_tpc, r.tpc);
      check("fact_taken", {31'b0, fact_taken}, {31'b0, r.taken});
      check("dir_fail", {31'b0, predict_dir_fail}, {31'b0, r.dfail});
      check("add_fail", {31'b0, predict_add_fail}, {31'b0, r.afail});
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, r.dfail | r.afail});
      if (r.dfail | r.afail) check("redirect_pc", redirect_pc, r.rpc);
    end else begin
      check("no_pulse", {29'b0, predict_dir_fail, predict_add_fail, redirect_valid}, 32'h0);
    end
    check("empty", {31'b0, empty}, {31'b0, model_q.size() == 0});
    check("res_err", {31'b0, res_err}, {31'b0, model_err});
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ppc, input logic [1:0] pt,
                      input logic hit);
    step(1'b1, pc, ppc, pt, hit, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tpc);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, tk, tpc, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_q.delete();
    sb_q.delete();
    model_err = 1'b0;
    check("rst_fact_pc", fact_pc, 32'h0);
    check("rst_fact_tpc", fact_tpc, 32'h0);
    check("rst_fact_taken", {31'b0, fact_taken}, 32'h0);
    check("rst_pulses", {29'b0, predict_dir_fail, predict_add_fail, redirect_valid}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_empty", {31'b0, empty}, 32'h1);
    check("rst_res_err", {31'b0, res_err}, 32'h0);
    check("rst_push_ready", {31'b0, push_ready}, 32'h1);
  endtask

  initial begin
    rstn = 1'b0;
    push_valid = 1'b0; push_pc = '0; push_pred_pc = '0; push_pred_taken = '0; push_hit = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_tpc = '0; flush = 1'b0;
    model_err = 1'b0;
    #1;
    @(posedge clk);
    #1;
    do_reset();

    // Correct taken prediction via slot 1
    push(32'h1C000004, 32'h1C000100, 2'b10, 1'b1);
    resolve(1'b1, 32'h1C000100);
    // Miss predicted not-taken, actually taken
    push(32'h1C000010, 32'h0, 2'b11, 1'b0);
    resolve(1'b1, 32'h1C000200);
    // Target mismatch, then direction mismatch on the same record
    push(32'h1C000020, 32'h1C000300, 2'b01, 1'b1);
    resolve(1'b1, 32'h1C000400);
    push(32'h1C000020, 32'h1C000300, 2'b01, 1'b1);
    resolve(1'b0, 32'h0);

    // Fill, try a ninth push, then resolve while pushing
    for (int i = 0; i < 8; i++) push(32'h1C001000 + 32'(i) * 8, 32'h0, 2'b00, 1'b0);
    push(32'h1C00F000, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h1C002000 + 32'(i) * 8, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    while (model_q.size() != 0) resolve(1'b0, 32'h0);

    // Mispredict with a concurrent push drops everything
    for (int i = 0; i < 3; i++) push(32'h1C003000 + 32'(i) * 4, 32'h1C004000, 2'b11, 1'b1);
    step(1'b1, 32'h1C005000, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();

    // Flush beats a same-cycle resolve and push
    for (int i = 0; i < 2; i++) push(32'h1C006000 + 32'(i) * 4, 32'h0, 2'b00, 1'b0);
    step(1'b1, 32'h1C007000, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h1C008000, 1'b1);
    idle();

    // Resolve on empty is sticky, cleared only by reset
    resolve(1'b1, 32'h1C009000);
    idle();
    push(32'h1C00A000, 32'h0, 2'b00, 1'b0);
    resolve(1'b0, 32'h0);
    do_reset();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
